// File: rtl/instrn_fetch_ctrl.sv
// Instruction fetch sequencer: sequential IMEM fetch with a req/ack handshake,
// a DEPTH-entry prefetch FIFO toward the core, and redirect handling that
// discards responses belonging to the abandoned fetch stream.
// Optional build macro FETCH_STATS_EN adds saturating fetch/redirect counters;
// without it Stat_Fetch and Stat_Flush are tied to zero.
module instrn_fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Redirect,
  input  logic [ADDR_W-1:0]          Redirect_Addr,
  input  logic                       Rd_Instr,
  output logic [DATA_W-1:0]          Instrn,
  output logic                       Instrn_Vld,
  output logic                       Imem_Req,
  output logic [ADDR_W-1:0]          Imem_Addr,
  input  logic                       Imem_Ack,
  input  logic [DATA_W-1:0]          Imem_Data,
  output logic [$clog2(DEPTH):0]     Fifo_Cnt,
  output logic [15:0]                Stat_Fetch,
  output logic [15:0]                Stat_Flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
  logic [ADDR_W-1:0] saved_addr, saved_addr_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt, cnt_after;
  logic              push, pop;

  // A redirect discards both the same-cycle pop and any same-cycle Ack data.
  assign pop  = Rd_Instr & (cnt != '0) & ~Redirect;
  assign push = (state == S_REQ) & Imem_Ack & ~Redirect;

  // Occupancy after this cycle's push/pop; decides whether REQ can continue back-to-back.
  always_comb begin
    cnt_after = cnt;
    if (push && !pop)      cnt_after = cnt + CNT_W'(1);
    else if (pop && !push) cnt_after = cnt - CNT_W'(1);
  end

  // State and fetch-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      fetch_addr <= '0;
      saved_addr <= '0;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      saved_addr <= saved_addr_nxt;
    end
  end

  // Next-state logic: keep one request outstanding and never retract it once issued.
  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    saved_addr_nxt = saved_addr;
    case (state)
      S_IDLE: begin
        if (Redirect) begin
          state_nxt      = S_REQ;
          fetch_addr_nxt = Redirect_Addr;
        end else if (cnt < FULL) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (Redirect) begin
          if (Imem_Ack) begin
            state_nxt      = S_REQ;
            fetch_addr_nxt = Redirect_Addr;
          end else begin
            state_nxt      = S_DISCARD;
            saved_addr_nxt = Redirect_Addr;
          end
        end else if (Imem_Ack) begin
          fetch_addr_nxt = fetch_addr + ADDR_W'(1);
          state_nxt      = (cnt_after < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (Imem_Ack) begin
          state_nxt      = S_REQ;
          fetch_addr_nxt = Redirect ? Redirect_Addr : saved_addr;
        end else if (Redirect) begin
          saved_addr_nxt = Redirect_Addr;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; Instrn forced to zero while empty.
  always_comb begin
    Imem_Req   = (state != S_IDLE);
    Imem_Addr  = fetch_addr;
    Instrn_Vld = (cnt != '0);
    Instrn     = Instrn_Vld ? mem[rd_ptr] : '0;
    Fifo_Cnt   = cnt;
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO on the same edge.
  always_ff @(posedge clk) begin
    if (reset || Redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt_after;
    end
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Imem_Data;
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      Stat_Fetch <= '0;
      Stat_Flush <= '0;
    end else begin
      if (push)     Stat_Fetch <= sat_inc(Stat_Fetch);
      if (Redirect) Stat_Flush <= sat_inc(Stat_Flush);
    end
  end
`else
  assign Stat_Fetch = '0;
  assign Stat_Flush = '0;
`endif

endmodule

// File: tb/tb_instrn_fetch_ctrl.sv
// Directed table-driven bench for instrn_fetch_ctrl. IMEM returns word
// 0xA5A500aa for address aa. Each table row gives the inputs for one cycle
// and the outputs expected in that same cycle (outputs are registered-state
// decodes, so they reflect the previous edges only).
module tb_instrn_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Redirect;
  logic [7:0]  Redirect_Addr;
  logic        Rd_Instr;
  logic [31:0] Instrn;
  logic        Instrn_Vld;
  logic        Imem_Req;
  logic [7:0]  Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [2:0]  Fifo_Cnt;
  logic [15:0] Stat_Fetch;
  logic [15:0] Stat_Flush;

  instrn_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Redirect(Redirect), .Redirect_Addr(Redirect_Addr),
    .Rd_Instr(Rd_Instr), .Instrn(Instrn), .Instrn_Vld(Instrn_Vld),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack),
    .Imem_Data(Imem_Data), .Fifo_Cnt(Fifo_Cnt),
    .Stat_Fetch(Stat_Fetch), .Stat_Flush(Stat_Flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wrd(input logic [7:0] a);
    return {16'hA5A5, 8'h00, a};
  endfunction

  assign Imem_Data = wrd(Imem_Addr);

  typedef struct {
    logic        rst;
    logic        redir;
    logic [7:0]  raddr;
    logic        rd;
    logic        ack;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_vld;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_instr;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  int total  = 0;
  int passed = 0;

  function automatic vec_t mk(input logic rst, input logic redir, input logic [7:0] raddr,
                              input logic rd, input logic ack, input logic req,
                              input logic [7:0] addr, input logic vld, input logic [2:0] cnt,
                              input logic [31:0] instr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.raddr = raddr; v.rd = rd; v.ack = ack;
    v.exp_req = req; v.exp_addr = addr; v.exp_vld = vld; v.exp_cnt = cnt; v.exp_instr = instr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  int pushes;

  initial begin
    //            rst re raddr rd ack | req addr  vld cnt instr
    tbl[0]  = mk(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 8'h00, 0, 1,   1, 8'h00, 0, 0, 0);
    tbl[3]  = mk(0, 0, 8'h00, 0, 1,   1, 8'h01, 1, 1, wrd(8'h00));
    tbl[4]  = mk(0, 0, 8'h00, 0, 1,   1, 8'h02, 1, 2, wrd(8'h00));
    tbl[5]  = mk(0, 0, 8'h00, 0, 1,   1, 8'h03, 1, 3, wrd(8'h00));
    tbl[6]  = mk(0, 0, 8'h00, 0, 1,   0, 8'h04, 1, 4, wrd(8'h00));
    tbl[7]  = mk(0, 0, 8'h00, 1, 0,   0, 8'h04, 1, 4, wrd(8'h00));
    tbl[8]  = mk(0, 0, 8'h00, 0, 0,   0, 8'h04, 1, 3, wrd(8'h01));
    tbl[9]  = mk(0, 0, 8'h00, 0, 1,   1, 8'h04, 1, 3, wrd(8'h01));
    tbl[10] = mk(0, 0, 8'h00, 1, 0,   0, 8'h05, 1, 4, wrd(8'h01));
    tbl[11] = mk(0, 0, 8'h00, 0, 0,   0, 8'h05, 1, 3, wrd(8'h02));
    tbl[12] = mk(0, 0, 8'h00, 1, 1,   1, 8'h05, 1, 3, wrd(8'h02));
    tbl[13] = mk(0, 0, 8'h00, 1, 0,   1, 8'h06, 1, 3, wrd(8'h03));
    tbl[14] = mk(0, 0, 8'h00, 1, 0,   1, 8'h06, 1, 2, wrd(8'h04));
    tbl[15] = mk(0, 0, 8'h00, 1, 0,   1, 8'h06, 1, 1, wrd(8'h05));
    tbl[16] = mk(0, 0, 8'h00, 1, 0,   1, 8'h06, 0, 0, 0);
    tbl[17] = mk(0, 0, 8'h00, 0, 1,   1, 8'h06, 0, 0, 0);
    tbl[18] = mk(0, 0, 8'h00, 0, 1,   1, 8'h07, 1, 1, wrd(8'h06));
    tbl[19] = mk(0, 1, 8'h40, 1, 0,   1, 8'h08, 1, 2, wrd(8'h06));
    tbl[20] = mk(0, 0, 8'h00, 0, 0,   1, 8'h08, 0, 0, 0);
    tbl[21] = mk(0, 0, 8'h00, 0, 0,   1, 8'h08, 0, 0, 0);
    tbl[22] = mk(0, 0, 8'h00, 0, 1,   1, 8'h08, 0, 0, 0);
    tbl[23] = mk(0, 0, 8'h00, 0, 1,   1, 8'h40, 0, 0, 0);
    tbl[24] = mk(0, 0, 8'h00, 0, 0,   1, 8'h41, 1, 1, wrd(8'h40));
    tbl[25] = mk(0, 1, 8'hFE, 0, 1,   1, 8'h41, 1, 1, wrd(8'h40));
    tbl[26] = mk(0, 0, 8'h00, 0, 1,   1, 8'hFE, 0, 0, 0);
    tbl[27] = mk(0, 0, 8'h00, 0, 1,   1, 8'hFF, 1, 1, wrd(8'hFE));
    tbl[28] = mk(0, 0, 8'h00, 0, 1,   1, 8'h00, 1, 2, wrd(8'hFE));
    tbl[29] = mk(0, 0, 8'h00, 0, 1,   1, 8'h01, 1, 3, wrd(8'hFE));
    tbl[30] = mk(0, 1, 8'h10, 0, 0,   0, 8'h02, 1, 4, wrd(8'hFE));
    tbl[31] = mk(0, 1, 8'h20, 0, 0,   1, 8'h10, 0, 0, 0);
    tbl[32] = mk(0, 1, 8'h30, 0, 0,   1, 8'h10, 0, 0, 0);
    tbl[33] = mk(0, 0, 8'h00, 0, 1,   1, 8'h10, 0, 0, 0);
    tbl[34] = mk(0, 0, 8'h00, 0, 1,   1, 8'h30, 0, 0, 0);
    tbl[35] = mk(1, 0, 8'h00, 0, 0,   1, 8'h31, 1, 1, wrd(8'h30));
    tbl[36] = mk(0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0);
    tbl[37] = mk(0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 0, 0);

    reset = 1'b1; Redirect = 1'b0; Redirect_Addr = '0; Rd_Instr = 1'b0; Imem_Ack = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      Redirect      = tbl[i].redir;
      Redirect_Addr = tbl[i].raddr;
      Rd_Instr      = tbl[i].rd;
      Imem_Ack      = tbl[i].ack;
      chk($sformatf("row%0d_req", i),  32'(Imem_Req),   32'(tbl[i].exp_req));
      chk($sformatf("row%0d_addr", i), 32'(Imem_Addr),  32'(tbl[i].exp_addr));
      chk($sformatf("row%0d_vld", i),  32'(Instrn_Vld), 32'(tbl[i].exp_vld));
      chk($sformatf("row%0d_cnt", i),  32'(Fifo_Cnt),   32'(tbl[i].exp_cnt));
      if (tbl[i].exp_vld)
        chk($sformatf("row%0d_instr", i), Instrn, tbl[i].exp_instr);
    end

    // Statistics: 10 accepted fetches (popped as they arrive), then 2 redirects.
    @(negedge clk);
    reset = 1'b1; Redirect = 1'b0; Rd_Instr = 1'b0; Imem_Ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("stat_fetch_reset", 32'(Stat_Fetch), 32'd0);
    chk("stat_flush_reset", 32'(Stat_Flush), 32'd0);
    pushes = 0;
    for (int c = 0; c < 200 && pushes < 10; c++) begin
      @(negedge clk);
      Imem_Ack = Imem_Req;
      Rd_Instr = Instrn_Vld;
      if (Imem_Req) pushes++;
    end
    chk("stat_ten_fetches_reached", 32'(pushes), 32'd10);
    @(negedge clk);
    Imem_Ack = 1'b0; Rd_Instr = 1'b0;
    Redirect = 1'b1; Redirect_Addr = 8'h50;
    @(negedge clk);
    Redirect_Addr = 8'h60;
    @(negedge clk);
    Redirect = 1'b0;
    chk("stat_cnt_after_redirect", 32'(Fifo_Cnt), 32'd0);
    chk("stat_discard_old_addr_req", 32'(Imem_Req), 32'd1);
`ifdef FETCH_STATS_EN
    chk("stat_fetch", 32'(Stat_Fetch), 32'd10);
    chk("stat_flush", 32'(Stat_Flush), 32'd2);
`else
    chk("stat_fetch", 32'(Stat_Fetch), 32'd0);
    chk("stat_flush", 32'(Stat_Flush), 32'd0);
`endif
    // Ack to the stale request lands at the newest redirect address.
    Imem_Ack = 1'b1;
    @(negedge clk);
    Imem_Ack = 1'b0;
    chk("stat_redirect_final_addr", 32'(Imem_Addr), 32'h60);
    chk("stat_stale_data_dropped", 32'(Fifo_Cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
